// File: rtl/axil_reg_master.sv
// AXI4-Lite slave that turns each PS access into a single write or read strobe on
// the TLK2711 register bus; reads complete after a fixed latency, with an idle gap after every access.
module axil_reg_master #(
  parameter int RD_LATENCY = 6,
  parameter int ACCESS_GAP = 4
) (
  input  logic        ps_clk,
  input  logic        ps_rst_n,
  input  logic [15:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [63:0] s_axi_wdata,
  input  logic [7:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [15:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [63:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic        o_reg_wen,
  output logic [15:0] o_reg_waddr,
  output logic [63:0] o_reg_wdata,
  output logic        o_reg_ren,
  output logic [15:0] o_reg_raddr,
  input  logic [63:0] i_reg_rdata,
  output logic        o_busy
);
  localparam logic [3:0] RD_LAT  = 4'(RD_LATENCY);
  localparam logic [3:0] GAP_CYC = 4'(ACCESS_GAP);
  localparam logic [1:0] OKAY    = 2'b00;
  localparam logic [1:0] SLVERR  = 2'b10;

  typedef enum logic [2:0] {IDLE, WR_STROBE, WR_RESP, RD_STROBE, RD_WAIT, RD_RESP, GAP} state_t;
  state_t state, state_n;

  logic        aw_full, w_full, ar_full;
  logic        aw_full_n, w_full_n, ar_full_n;
  logic [15:0] aw_addr, ar_addr, rd_addr;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic [3:0]  cnt;
  logic        last_rd;
  logic        aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic        wr_elig, rd_elig, wr_ok, rd_ok, grant_wr, grant_rd;

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;
  assign b_hs  = s_axi_bvalid & s_axi_bready;
  assign r_hs  = s_axi_rvalid & s_axi_rready;

  // A read accepted this very cycle is granted straight away, saving the buffer round trip.
  assign rd_addr = ar_full ? ar_addr : s_axi_araddr;
  assign wr_elig = aw_full & w_full;
  assign rd_elig = ar_full | ar_hs;
  assign wr_ok   = (aw_addr[2:0] == 3'b000) && (w_strb == 8'hFF);
  assign rd_ok   = (rd_addr[2:0] == 3'b000);

  assign aw_full_n = (aw_full & ~b_hs) | aw_hs;
  assign w_full_n  = (w_full & ~b_hs) | w_hs;
  assign ar_full_n = (ar_full & ~r_hs) | ar_hs;

  assign s_axi_bvalid = (state == WR_RESP);
  assign s_axi_rvalid = (state == RD_RESP);
  assign o_reg_wen    = (state == WR_STROBE);
  assign o_reg_ren    = (state == RD_STROBE);
  assign o_busy       = (state != IDLE);

  always_comb begin
    state_n  = state;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    case (state)
      IDLE: begin
        // On contention the side that lost last time wins.
        if (wr_elig && (!rd_elig || last_rd)) grant_wr = 1'b1;
        else if (rd_elig)                     grant_rd = 1'b1;
        if (grant_wr)      state_n = wr_ok ? WR_STROBE : WR_RESP;
        else if (grant_rd) state_n = rd_ok ? RD_STROBE : RD_RESP;
      end
      WR_STROBE: state_n = WR_RESP;
      WR_RESP:   if (s_axi_bready) state_n = GAP;
      RD_STROBE: state_n = RD_WAIT;
      RD_WAIT:   if (cnt == RD_LAT) state_n = RD_RESP;
      RD_RESP:   if (s_axi_rready) state_n = GAP;
      GAP:       if (cnt <= 4'd1) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge ps_clk or negedge ps_rst_n) begin
    if (!ps_rst_n) begin
      state         <= IDLE;
      aw_full       <= 1'b0;
      w_full        <= 1'b0;
      ar_full       <= 1'b0;
      aw_addr       <= '0;
      ar_addr       <= '0;
      w_data        <= '0;
      w_strb        <= '0;
      cnt           <= '0;
      last_rd       <= 1'b1;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_arready <= 1'b0;
      s_axi_bresp   <= OKAY;
      s_axi_rresp   <= OKAY;
      s_axi_rdata   <= '0;
      o_reg_waddr   <= '0;
      o_reg_wdata   <= '0;
      o_reg_raddr   <= '0;
    end else begin
      state         <= state_n;
      aw_full       <= aw_full_n;
      w_full        <= w_full_n;
      ar_full       <= ar_full_n;
      s_axi_awready <= ~aw_full_n;
      s_axi_wready  <= ~w_full_n;
      s_axi_arready <= (state_n == IDLE) && !ar_full_n;
      if (aw_hs) aw_addr <= s_axi_awaddr;
      if (w_hs) begin
        w_data <= s_axi_wdata;
        w_strb <= s_axi_wstrb;
      end
      if (ar_hs) ar_addr <= s_axi_araddr;
      if (grant_wr) begin
        last_rd     <= 1'b0;
        s_axi_bresp <= wr_ok ? OKAY : SLVERR;
        if (wr_ok) begin
          o_reg_waddr <= aw_addr;
          o_reg_wdata <= w_data;
        end
      end
      if (grant_rd) begin
        last_rd <= 1'b1;
        if (rd_ok) o_reg_raddr <= rd_addr;
        else begin
          s_axi_rdata <= '0;
          s_axi_rresp <= SLVERR;
        end
      end
      if (state == RD_WAIT && state_n == RD_RESP) begin
        s_axi_rdata <= i_reg_rdata;
        s_axi_rresp <= OKAY;
      end
      // One counter serves both the read latency and the post-access gap.
      case (state)
        RD_STROBE: cnt <= 4'd1;
        RD_WAIT:   cnt <= cnt + 4'd1;
        GAP:       if (cnt != 4'd0) cnt <= cnt - 4'd1;
        default:   cnt <= cnt;
      endcase
      if (state_n == GAP && state != GAP) cnt <= GAP_CYC;
    end
  end
endmodule

// File: tb/tb_axil_reg_master.sv
// Directed bench for axil_reg_master: a register-bus model that presents read data only in the
// expected cycle, AXI driver tasks, and checks for latency, legality, arbitration and reset.
module tb_axil_reg_master;
  localparam int RD_LAT = 6;
  localparam int GAP_N  = 4;

  logic        ps_clk = 1'b0, ps_rst_n = 1'b0;
  logic [15:0] s_axi_awaddr = '0, s_axi_araddr = '0;
  logic        s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_arvalid = 1'b0;
  logic        s_axi_bready = 1'b0, s_axi_rready = 1'b0;
  logic [63:0] s_axi_wdata = '0, i_reg_rdata = '0;
  logic [7:0]  s_axi_wstrb = '0;
  logic        s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic [63:0] s_axi_rdata, o_reg_wdata;
  logic        o_reg_wen, o_reg_ren, o_busy;
  logic [15:0] o_reg_waddr, o_reg_raddr;

  always #5 ps_clk = ~ps_clk;

  axil_reg_master #(.RD_LATENCY(RD_LAT), .ACCESS_GAP(GAP_N)) dut (
    .ps_clk(ps_clk), .ps_rst_n(ps_rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .o_reg_wen(o_reg_wen),
    .o_reg_waddr(o_reg_waddr), .o_reg_wdata(o_reg_wdata), .o_reg_ren(o_reg_ren),
    .o_reg_raddr(o_reg_raddr), .i_reg_rdata(i_reg_rdata), .o_busy(o_busy)
  );

  int          n_chk = 0, n_fail = 0;
  int          cyc = 0;
  int          n_wen = 0, n_ren = 0, n_rst_strb = 0;
  int          ren_cyc = -100, wen_cyc = -100, last_strb = -100, min_gap = 1000;
  int          hs_aw = 0, hs_w = 0, hs_ar = 0, bv_cyc = 0, rv_cyc = 0;
  logic [15:0] ren_addr = '0, wen_addr = '0;
  logic [63:0] wen_data = '0;
  logic [7:0]  slog [0:63];
  int          slen = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] reg_val(input logic [15:0] a);
    return (a == 16'h0050) ? 64'hA000_0000_0000_0015 : {16'hC0DE, a, 32'h1234_5678};
  endfunction

  initial forever @(posedge ps_clk) cyc++;

  // Register-bus model: correct data only RD_LAT cycles after the strobe, a decoy one cycle earlier.
  initial forever begin
    @(negedge ps_clk);
    if (o_reg_wen || o_reg_ren) begin
      if (!ps_rst_n) n_rst_strb++;
      if (cyc - last_strb - 1 < min_gap) min_gap = cyc - last_strb - 1;
      last_strb = cyc;
      if (slen < 64) begin
        slog[slen] = o_reg_wen ? 8'h57 : 8'h52;
        slen++;
      end
    end
    if (o_reg_wen) begin
      n_wen++; wen_cyc = cyc; wen_addr = o_reg_waddr; wen_data = o_reg_wdata;
    end
    if (o_reg_ren) begin
      n_ren++; ren_cyc = cyc; ren_addr = o_reg_raddr;
    end
    if (cyc == ren_cyc + RD_LAT)          i_reg_rdata = reg_val(ren_addr);
    else if (cyc == ren_cyc + RD_LAT - 1) i_reg_rdata = ~reg_val(ren_addr);
    else                                  i_reg_rdata = '0;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge ps_clk);
    #1;
  endtask

  task automatic send_aw(input logic [15:0] a);
    bit done;
    done = 0;
    s_axi_awaddr = a; s_axi_awvalid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge ps_clk);
      if (s_axi_awready) begin done = 1; hs_aw = cyc; end
    end
    if (!done) chk("aw_timeout", 0, 1);
    tick(1);
    s_axi_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] d, input logic [7:0] s);
    bit done;
    done = 0;
    s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge ps_clk);
      if (s_axi_wready) begin done = 1; hs_w = cyc; end
    end
    if (!done) chk("w_timeout", 0, 1);
    tick(1);
    s_axi_wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [15:0] a);
    bit done;
    done = 0;
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge ps_clk);
      if (s_axi_arready) begin done = 1; hs_ar = cyc; end
    end
    if (!done) chk("ar_timeout", 0, 1);
    tick(1);
    s_axi_arvalid = 1'b0;
  endtask

  task automatic get_b(input string tag, input logic [1:0] exp);
    bit done;
    done = 0;
    s_axi_bready = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge ps_clk);
      if (s_axi_bvalid) begin
        done = 1; bv_cyc = cyc;
        chk({tag, "_bresp"}, s_axi_bresp, exp);
      end
    end
    if (!done) chk({tag, "_b_timeout"}, 0, 1);
    tick(1);
    s_axi_bready = 1'b0;
  endtask

  task automatic get_r(input string tag, input logic [63:0] exp_d, input logic [1:0] exp_r);
    bit done;
    done = 0;
    s_axi_rready = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge ps_clk);
      if (s_axi_rvalid) begin
        done = 1; rv_cyc = cyc;
        chk({tag, "_rdata"}, s_axi_rdata, exp_d);
        chk({tag, "_rresp"}, s_axi_rresp, exp_r);
      end
    end
    if (!done) chk({tag, "_r_timeout"}, 0, 1);
    tick(1);
    s_axi_rready = 1'b0;
  endtask

  initial begin
    int    n0, pre;
    bit    seen;
    string exp_ord;
    exp_ord = "RWRWR";

    // Reset state
    repeat (3) @(negedge ps_clk);
    chk("rst_ctrl", {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid,
                     s_axi_bresp, s_axi_rresp, o_reg_wen, o_reg_ren, o_busy}, 0);
    chk("rst_rdata", s_axi_rdata, 0);
    chk("rst_addr", {o_reg_waddr, o_reg_raddr}, 0);
    chk("rst_wdata", o_reg_wdata, 0);
    tick(1);
    ps_rst_n = 1'b1;
    tick(1);
    chk("idle_ready", {s_axi_awready, s_axi_wready, s_axi_arready, o_busy}, 4'b1110);

    // Legal write, AW and W together
    n0 = n_wen;
    fork
      send_aw(16'h0020);
      send_w(64'h0000_0000_8000_0000, 8'hFF);
    join
    get_b("t1", 2'b00);
    chk("t1_nwen", n_wen - n0, 1);
    chk("t1_waddr", wen_addr, 16'h0020);
    chk("t1_wdata", wen_data, 64'h0000_0000_8000_0000);
    chk("t1_strb_lat", wen_cyc - hs_aw, 2);
    chk("t1_b_lat", bv_cyc - hs_aw, 3);

    // W five cycles ahead of AW
    n0 = n_wen;
    send_w(64'h1122_3344_5566_7788, 8'hFF);
    tick(5);
    chk("t2_no_early_strobe", n_wen - n0, 0);
    send_aw(16'h0038);
    get_b("t2", 2'b00);
    chk("t2_nwen", n_wen - n0, 1);
    chk("t2_waddr", wen_addr, 16'h0038);
    chk("t2_wdata", wen_data, 64'h1122_3344_5566_7788);

    // Legal read with the decoy value one cycle early
    send_ar(16'h0050);
    chk("t3_gap_min", (hs_ar - bv_cyc) >= GAP_N + 1, 1);
    chk("t3_gap_max", (hs_ar - bv_cyc) <= GAP_N + 2, 1);
    get_r("t3", 64'hA000_0000_0000_0015, 2'b00);
    chk("t3_ren_lat", ren_cyc - hs_ar, 1);
    chk("t3_raddr", ren_addr, 16'h0050);
    chk("t3_r_lat", rv_cyc - hs_ar, RD_LAT + 2);

    // Illegal accesses produce no strobes
    n0 = n_wen + n_ren;
    fork
      send_aw(16'h0023);
      send_w(64'hFFFF_0000_FFFF_0000, 8'hFF);
    join
    get_b("t4_unaligned", 2'b10);
    fork
      send_aw(16'h0028);
      send_w(64'h0F0F_0F0F_0F0F_0F0F, 8'h0F);
    join
    get_b("t4_partial", 2'b10);
    send_ar(16'h0041);
    get_r("t4_rd", 64'h0, 2'b10);
    chk("t4_no_strobes", n_wen + n_ren - n0, 0);

    // Arbitration under contention, with read back-pressure
    n0 = slen;
    send_ar(16'h0060);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge ps_clk);
      if (s_axi_rvalid) seen = 1;
    end
    if (!seen) chk("t5_r0_timeout", 0, 1);
    tick(1);
    pre = n_wen + n_ren;
    fork
      send_aw(16'h0100);
      send_w(64'hAAAA_0000_0000_0001, 8'hFF);
    join
    tick(20);
    chk("t5_stall_strobes", n_wen + n_ren - pre, 0);
    chk("t5_stall_rvalid", s_axi_rvalid, 1);
    chk("t5_stall_rdata", s_axi_rdata, reg_val(16'h0060));
    fork
      send_ar(16'h0108);
      begin
        get_r("t5_r0", reg_val(16'h0060), 2'b00);
        get_b("t5_wa", 2'b00);
        fork
          send_aw(16'h0110);
          send_w(64'hCCCC_0000_0000_0003, 8'hFF);
        join
      end
    join
    fork
      send_ar(16'h0118);
      begin
        get_r("t5_rb", reg_val(16'h0108), 2'b00);
        get_b("t5_wc", 2'b00);
        get_r("t5_rd", reg_val(16'h0118), 2'b00);
      end
    join
    chk("t5_nstrobes", slen - n0, 5);
    for (int i = 0; i < 5; i++)
      if (n0 + i < 64) chk($sformatf("t5_order%0d", i), slog[n0 + i], exp_ord[i]);
    chk("t5_last_wdata", wen_data, 64'hCCCC_0000_0000_0003);
    chk("min_gap_ok", min_gap >= GAP_N, 1);

    // Reset while waiting for read data
    send_ar(16'h0070);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge ps_clk);
      if (o_reg_ren) seen = 1;
    end
    if (!seen) chk("t6_ren_timeout", 0, 1);
    repeat (3) @(negedge ps_clk);
    chk("t6_busy_before", o_busy, 1);
    #2 ps_rst_n = 1'b0;
    #1;
    chk("t6_async_ctrl", {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid,
                          s_axi_bresp, s_axi_rresp, o_reg_wen, o_reg_ren, o_busy}, 0);
    chk("t6_async_rdata", s_axi_rdata, 0);
    chk("t6_async_addr", {o_reg_waddr, o_reg_raddr}, 0);
    chk("t6_async_wdata", o_reg_wdata, 0);
    pre = n_wen + n_ren;
    tick(4);
    ps_rst_n = 1'b1;
    tick(1);
    chk("t6_arready_back", {s_axi_arready, s_axi_rvalid, o_busy}, 3'b100);
    chk("t6_no_strobe_in_rst", n_rst_strb, 0);
    tick(12);
    chk("t6_aborted_quiet", {s_axi_rvalid, 32'(n_wen + n_ren - pre)}, 0);
    send_ar(16'h0050);
    get_r("t6_fresh", 64'hA000_0000_0000_0015, 2'b00);
    chk("t6_fresh_lat", rv_cyc - hs_ar, RD_LAT + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/axil_reg_master.md
Name: axil_reg_master

Overview:
- PS-side initiator for the TLK2711 register bus.
- Accepts AXI4-Lite slave transactions from the PS master port (16-bit address, 64-bit data).
- Turns each transaction into single-cycle write or read strobes on the register bus.
- Reads: waits a fixed, parameterised latency, then captures the returned register data into the AXI R channel. The bus has no ready or ack signal, so the latency is the only completion indicator.

Parameters:
- RD_LATENCY, 6: ps_clk cycles from o_reg_ren high to i_reg_rdata valid. Legal range 1..15.
- ACCESS_GAP, 4: minimum idle ps_clk cycles after any strobe before the next strobe. Legal range 0..15.

Ports:
- ps_clk  in  1  clock; all logic is on the rising edge.
- ps_rst_n  in  1  reset, asynchronous assert, active-low.
- s_axi_awaddr  in  16  write address.
- s_axi_awvalid / s_axi_awready  in/out  1  AW handshake.
- s_axi_wdata  in  64  write data.
- s_axi_wstrb  in  8  byte strobes.
- s_axi_wvalid / s_axi_wready  in/out  1  W handshake.
- s_axi_bresp  out  2  write response: 00 OKAY, 10 SLVERR.
- s_axi_bvalid / s_axi_bready  out/in  1  B handshake.
- s_axi_araddr  in  16  read address.
- s_axi_arvalid / s_axi_arready  in/out  1  AR handshake.
- s_axi_rdata  out  64  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rvalid / s_axi_rready  out/in  1  R handshake.
- o_reg_wen  out  1  one-cycle write strobe.
- o_reg_waddr  out  16  write address, valid while o_reg_wen=1.
- o_reg_wdata  out  64  write data, valid while o_reg_wen=1.
- o_reg_ren  out  1  one-cycle read strobe.
- o_reg_raddr  out  16  read address, valid while o_reg_ren=1.
- i_reg_rdata  in  64  register read data, sampled RD_LATENCY cycles after o_reg_ren.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: while ps_rst_n=0, all outputs are 0 and the FSM is in IDLE.
  - Covers all ready/valid signals, bresp, rresp, rdata, all strobes and all o_reg buses.
  - The AW and W holding buffers are emptied.
- AW and W channels are captured independently into one-entry buffers.
  - awready=1 when the AW buffer is empty; wready=1 when the W buffer is empty.
  - The registered ready deasserts in the cycle after a handshake.
- arready=1 only in IDLE when no read is captured and the gap counter is 0.
- FSM states: IDLE, WR_STROBE, WR_RESP, RD_STROBE, RD_WAIT, RD_RESP, GAP.
- Arbitration in IDLE with the gap counter at 0:
  - Write is eligible when both the AW and W buffers are full; read is eligible when AR has been accepted.
  - Only one eligible: take it.
  - Both eligible: grant the opposite of the last grant. After reset the last grant is read, so write wins first.
- Write legality check: awaddr[2:0]=000 and wstrb=8'hFF.
  - Legal: WR_STROBE drives o_reg_wen=1 for exactly one cycle with the buffered addr/data, bresp=00.
  - Illegal: no strobe is issued, bresp=10.
  - Either way the FSM goes to WR_RESP and the AW and W buffers are released on the B handshake.
- WR_RESP: bvalid=1 until bready; then go to GAP.
- Read legality check: araddr[2:0]=000.
  - Legal: RD_STROBE drives o_reg_ren=1 for one cycle. RD_WAIT counts RD_LATENCY cycles, samples i_reg_rdata at the end, rresp=00.
  - Illegal: no strobe and no wait; rdata=0, rresp=10.
- RD_RESP: rvalid=1 with rdata and rresp held stable until rready; then go to GAP.
- GAP: counts ACCESS_GAP cycles, then returns to IDLE.
  - ACCESS_GAP=0 returns to IDLE in the next cycle.
  - GAP is entered after illegal accesses too.
- Outside strobe cycles, o_reg_waddr, o_reg_wdata and o_reg_raddr hold their last values. Consumers qualify them with the strobe.
- Back-pressure:
  - bready or rready low stalls indefinitely; no further strobes are issued while stalled.
  - New AW/W beats may still be buffered while stalled, one entry each.
- Latency, idle, legal write with AW and W in the same cycle:
  - AW/W handshake in cycle 0, strobe in cycle 2, bvalid in cycle 3.
- Latency, idle, legal read:
  - AR handshake in cycle 0, strobe in cycle 1, rdata sampled in cycle 1+RD_LATENCY, rvalid in the next cycle.
- A reset assertion mid-transaction aborts immediately. No strobe is issued after ps_rst_n falls, and pending responses are dropped.

Test Plan:
- Write awaddr=16'h0020, wdata=64'h0000_0000_8000_0000, wstrb=FF, AW and W together:
  - exactly one o_reg_wen pulse with o_reg_waddr=0020 and that data;
  - bresp=00 with bvalid 3 cycles after the handshake.
- W presented 5 cycles before AW:
  - no strobe until AW is accepted;
  - one strobe with the correct pairing of address and data.
- Read araddr=16'h0050, i_reg_rdata driven to 64'hA000_0000_0000_0015 exactly RD_LATENCY=6 cycles after o_reg_ren:
  - rdata=A000_0000_0000_0015, rresp=00.
  - The value driven one cycle earlier must not appear.
- Unaligned write awaddr=16'h0023, then write with wstrb=0F, then read araddr=16'h0041:
  - no strobes at all;
  - bresp=10 twice, rresp=10 with rdata=0.
- Read and write pending in the same idle cycle, twice in a row:
  - grant order write, read, write, read;
  - at least ACCESS_GAP idle cycles between any two strobes;
  - rready held low for 20 cycles produces no extra strobes.
- Assert ps_rst_n=0 during RD_WAIT:
  - all outputs go 0 asynchronously;
  - after release, arready returns and a fresh read completes correctly.
